// File: rtl/clk_div_ctrl.sv
// Divisor reprogramming sequencer for a clk_div instance: gates the divided clock while it
// is low, swaps the divisor, lets it settle, then ungates so consumers never see a glitch.
//
// state    | meaning
// IDLE     | divider running, ready for a request
// WAIT_LOW | waiting for synchronized divided clock low (bounded by timeout)
// GATE     | output gated, settling before the divisor update
// UPDATE   | new divisor applied to the divider
// SETTLE   | output gated, settling after the divisor update
// DONE     | one-cycle completion pulse
module clk_div_ctrl #(
    parameter int DIV_WIDTH      = 4,
    parameter int DEFAULT_DIV    = 1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] req_div_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 div_clk_i,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 clk_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0]      ST_LOAD = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic [2:0] {
        IDLE, WAIT_LOW, GATE, UPDATE, SETTLE, DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 div_clk_meta, div_clk_s;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]      st_cnt_q, st_cnt_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 clk_en_q, clk_en_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            div_clk_meta <= 1'b0;
            div_clk_s    <= 1'b0;
            to_cnt_q     <= '0;
            st_cnt_q     <= '0;
            pend_q       <= '0;
            div_q        <= DIV_RST;
            clk_en_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_clk_meta <= div_clk_i;
            div_clk_s    <= div_clk_meta;
            to_cnt_q     <= to_cnt_d;
            st_cnt_q     <= st_cnt_d;
            pend_q       <= pend_d;
            div_q        <= div_d;
            clk_en_q     <= clk_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        st_cnt_d  = st_cnt_q;
        pend_d    = pend_q;
        div_d     = div_q;
        clk_en_d  = clk_en_q;
        timeout_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pend_d = req_div_i;
                    if (req_div_i == div_q) begin
                        state_d = DONE;
                    end else begin
                        state_d  = WAIT_LOW;
                        to_cnt_d = '0;
                    end
                end
            end
            WAIT_LOW: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // A stuck-high divided clock still gets gated after the timeout.
                if (!div_clk_s || to_cnt_q == TO_LAST) begin
                    timeout_o = div_clk_s;
                    to_cnt_d  = to_cnt_q;
                    state_d   = GATE;
                    clk_en_d  = 1'b0;
                    st_cnt_d  = ST_LOAD;
                end
            end
            GATE: begin
                if (st_cnt_q == '0) begin
                    state_d = UPDATE;
                end else begin
                    st_cnt_d = st_cnt_q - ST_W'(1);
                end
            end
            UPDATE: begin
                div_d    = pend_q;
                st_cnt_d = ST_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (st_cnt_q == '0) begin
                    clk_en_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    st_cnt_d = st_cnt_q - ST_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign div_o       = div_q;
    assign clk_en_o    = clk_en_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: scripted scenarios then random requests, divided-clock patterns and
// resets, checked every cycle against a timeline model derived from the phase durations.
module tb_clk_div_ctrl;
    localparam int DW         = 4;
    localparam int DEF        = 1;
    localparam int S          = 4;
    localparam int T          = 64;
    localparam int NCYC       = 4000;
    localparam int RAND_START = 610;
    localparam int DSZ        = NCYC + T + 4;

    logic          clk = 1'b0;
    logic          rst, req_valid, dclk;
    logic [DW-1:0] req_div;
    logic          req_ready, clk_en, busy, done, timeout;
    logic [DW-1:0] div;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_WIDTH     (DW),
        .DEFAULT_DIV   (DEF),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_div_i  (req_div),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .div_clk_i  (dclk),
        .div_o      (div),
        .clk_en_o   (clk_en),
        .busy_o     (busy),
        .done_o     (done),
        .timeout_o  (timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // div_clk_i value driven in each cycle; the model reads ahead in it to find the low point
    bit dclk_a [DSZ];

    // model: one outstanding transaction described by acceptance cycle and phase lengths
    int act, ta, tw, tto, tsame, old_div, new_div, cur_div, idle_from;
    int e_busy, e_rdy, e_en, e_div, e_done, e_to, g;
    int vld, d, rst_now, found, len, lvl, idx;
    int en_low_w0, done_w0, to_w2, done_after_rst;

    initial begin
        for (int i = 0; i < DSZ; i++) dclk_a[i] = 1'b0;
        for (int i = 105; i <= 120; i++) dclk_a[i] = 1'b1;
        for (int i = 205; i <= 300; i++) dclk_a[i] = 1'b1;
        idx = RAND_START;
        while (idx < DSZ) begin
            len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(66, 90))
                                               : int'($urandom_range(1, 8));
            lvl = int'($urandom_range(0, 1));
            for (int k = 0; k < len && idx < DSZ; k++) begin
                dclk_a[idx] = lvl[0];
                idx++;
            end
        end

        act = 0; ta = 0; tw = 0; tto = 0; tsame = 0;
        old_div = DEF; new_div = DEF; cur_div = DEF; idle_from = 0;
        en_low_w0 = 0; done_w0 = -1; to_w2 = 0; done_after_rst = 0;
        rst = 1'b1; req_valid = 1'b0; req_div = '0; dclk = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if (act != 0 && n >= idle_from) begin
                cur_div = new_div;
                act     = 0;
            end

            e_busy = 0; e_rdy = 1; e_en = 1; e_div = cur_div; e_done = 0; e_to = 0;
            if (act != 0) begin
                e_busy = 1;
                e_rdy  = 0;
                if (tsame != 0) begin
                    e_done = 1;
                end else begin
                    g      = ta + tw;
                    e_to   = (tto != 0 && n == g) ? 1 : 0;
                    e_en   = (n >= g + 1 && n <= g + 2*S + 1) ? 0 : 1;
                    e_div  = (n >= g + S + 2) ? new_div : old_div;
                    e_done = (n == g + 2*S + 2) ? 1 : 0;
                end
            end

            if (n >= 3) begin
                check_val($sformatf("div@%0d", n),     32'(div),       32'(e_div));
                check_val($sformatf("clk_en@%0d", n),  32'(clk_en),    32'(e_en));
                check_val($sformatf("busy@%0d", n),    32'(busy),      32'(e_busy));
                check_val($sformatf("ready@%0d", n),   32'(req_ready), 32'(e_rdy));
                check_val($sformatf("done@%0d", n),    32'(done),      32'(e_done));
                check_val($sformatf("timeout@%0d", n), 32'(timeout),   32'(e_to));
            end

            if (n == 3) begin
                check_val("rst_div", 32'(div), DEF);
                check_val("rst_clk_en", 32'(clk_en), 1);
                check_val("rst_ready", 32'(req_ready), 1);
                check_val("rst_busy", 32'(busy), 0);
                check_val("rst_done", 32'(done), 0);
                check_val("rst_timeout", 32'(timeout), 0);
            end
            if (n >= 10 && n < 110) begin
                if (clk_en === 1'b0) en_low_w0++;
                if (done === 1'b1 && done_w0 < 0) done_w0 = n;
            end
            if (n == 110) begin
                check_val("basic_gated_len", en_low_w0, 2*S + 1);
                check_val("basic_done_lat", done_w0 - 10, 2*S + 3);
            end
            if (n >= 210 && n < 310 && timeout === 1'b1) to_w2++;
            if (n == 310) check_val("timeout_pulses", to_w2, 1);
            if (n == 440) check_val("busy_final_div", 32'(div), 7);
            if (n == 519) begin
                check_val("midrst_div", 32'(div), DEF);
                check_val("midrst_clk_en", 32'(clk_en), 1);
                check_val("midrst_ready", 32'(req_ready), 1);
                check_val("midrst_busy", 32'(busy), 0);
            end
            if (n >= 519 && n < 600 && done === 1'b1) done_after_rst++;
            if (n == 600) check_val("midrst_no_done", done_after_rst, 0);

            vld = 0;
            d   = 0;
            if (n >= 10 && n < RAND_START) begin
                case ((n - 10) / 100)
                    0: if ((n - 10) % 100 == 0) begin vld = 1; d = 5; end
                    1: if ((n - 10) % 100 == 0) begin vld = 1; d = 2; end
                    2: if ((n - 10) % 100 == 0) begin vld = 1; d = 9; end
                    3: if ((n - 10) % 100 == 0) begin vld = 1; d = 9; end
                    4: begin
                        if ((n - 10) % 100 == 0) begin vld = 1; d = 3; end
                        else if ((n - 10) % 100 <= 12) begin vld = 1; d = 7; end
                    end
                    5: if ((n - 10) % 100 == 0) begin vld = 1; d = 6; end
                    default: vld = 0;
                endcase
            end else if (n >= RAND_START) begin
                vld = ($urandom_range(0, 2) == 0) ? 1 : 0;
                d   = ($urandom_range(0, 3) == 0) ? cur_div : int'($urandom_range(0, 15));
            end
            rst_now = (n < 3 || n == 518 ||
                       (n >= RAND_START && $urandom_range(0, 499) == 0)) ? 1 : 0;

            if (rst_now != 0) begin
                vld       = 0;
                act       = 0;
                cur_div   = DEF;
                idle_from = n + 1;
                // the synchronizer is cleared, so the first post-reset sample reads low
                dclk_a[n] = 1'b0;
            end else if (vld != 0 && n >= idle_from) begin
                ta      = n;
                act     = 1;
                old_div = cur_div;
                new_div = d;
                tsame   = (d == cur_div) ? 1 : 0;
                if (tsame != 0) begin
                    idle_from = n + 2;
                end else begin
                    tw = T; tto = 1; found = 0;
                    for (int k = 1; k <= T; k++) begin
                        if (found == 0 && dclk_a[n + k - 2] == 1'b0) begin
                            tw = k; tto = 0; found = 1;
                        end
                    end
                    idle_from = n + tw + 2*S + 3;
                end
            end

            rst       = rst_now[0];
            req_valid = vld[0];
            req_div   = d[DW-1:0];
            dclk      = dclk_a[n];
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
